// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers.
// Contents:
//   ST_EMPTY/ST_ONE/ST_FULL - stage state encoding, read as {skid_v, main_v}
//   PIPE_DATA_W             - default payload width
//   PIPE_CNT_W              - default performance counter width
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;

   localparam int unsigned PIPE_DATA_W = 64;
   localparam int unsigned PIPE_CNT_W  = 8;

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage register.
// Signals:
//   in_valid/in_ready/in_data    - upstream side
//   out_valid/out_ready/out_data - downstream side
// Modports:
//   slave  - the stage register itself
//   master - the environment driving upstream and consuming downstream
interface elastic_pipe_reg_if
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a per-cycle increment of 0..2.
// Ports:
//   clk, rst - clock (rising edge), asynchronous active-high reset
//   i_inc    - amount to add this cycle (0..2)
//   o_cnt    - current count, sticks at 2^W-1
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   i_inc,
   output logic [W-1:0] o_cnt
);

   localparam int unsigned SumW = W + 1;

   logic [W-1:0] r_cnt;
   logic [W:0]   w_sum;
   logic [W-1:0] w_cnt_d;

   // One extra bit catches the wrap; max sum 2^W+1 always sets it.
   assign w_sum   = {1'b0, r_cnt} + SumW'(i_inc);
   assign w_cnt_d = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage register with optional 2-entry skid buffer,
// legacy freeze/flush controls and a squashed-entry counter.
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   i_freeze      - hazard stall, no transfer on either side
//   i_flush       - squash every held entry
//   io_pipe       - valid/ready handshake bundle (slave side)
//   o_occupancy   - entries held, 0..2
//   o_squash_cnt  - saturating count of valid entries dropped by flush
module elastic_pipe_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W            = PIPE_DATA_W,
   parameter bit          SKID_EN           = 1'b1,
   parameter bit          FLUSH_OVER_FREEZE = 1'b0,
   parameter bit          ZERO_ON_FLUSH     = 1'b1,
   parameter int unsigned CNT_W             = PIPE_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_freeze,
   input  logic                i_flush,
   elastic_pipe_reg_if.slave   io_pipe,
   output logic [1:0]          o_occupancy,
   output logic [CNT_W-1:0]    o_squash_cnt
);

   logic              r_main_v;
   logic              r_skid_v;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;

   logic              w_main_v_d;
   logic              w_skid_v_d;
   logic [DATA_W-1:0] w_main_d;
   logic [DATA_W-1:0] w_skid_d;

   logic [1:0]        w_state;
   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_flush_eff;
   logic [1:0]        w_squash_inc;

   assign w_state     = {r_skid_v, r_main_v};
   assign w_flush_eff = i_flush & (~i_freeze | FLUSH_OVER_FREEZE);

   // Without the skid slot the stage can only take a new word when the
   // current one leaves in the same cycle.
   assign w_in_ready  = ~i_freeze & (SKID_EN ? ~r_skid_v : (~r_main_v | io_pipe.out_ready));
   assign w_in_fire   = io_pipe.in_valid & w_in_ready;
   assign w_out_fire  = r_main_v & io_pipe.out_ready & ~i_freeze;

   // Freeze needs no explicit hold: both fire terms are already gated by it.
   always_comb begin
      w_main_v_d = r_main_v;
      w_skid_v_d = r_skid_v;
      w_main_d   = r_main;
      w_skid_d   = r_skid;
      if (w_flush_eff) begin
         w_main_v_d = 1'b0;
         w_skid_v_d = 1'b0;
         if (ZERO_ON_FLUSH) begin
            w_main_d = '0;
            w_skid_d = '0;
         end
      end else begin
         unique case (w_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_main_v_d = 1'b1;
                  w_main_d   = io_pipe.in_data;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_d = io_pipe.in_data;
               end else if (w_in_fire && SKID_EN) begin
                  w_skid_v_d = 1'b1;
                  w_skid_d   = io_pipe.in_data;
               end else if (w_out_fire) begin
                  w_main_v_d = 1'b0;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_main_d   = r_skid;
                  w_skid_v_d = 1'b0;
               end
            end
            default: begin
               // skid without main is unreachable; fall back to empty
               w_main_v_d = 1'b0;
               w_skid_v_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_main   <= '0;
         r_skid   <= '0;
      end else begin
         r_main_v <= w_main_v_d;
         r_skid_v <= w_skid_v_d;
         r_main   <= w_main_d;
         r_skid   <= w_skid_d;
      end
   end

   assign w_squash_inc = w_flush_eff ? ({1'b0, r_main_v} + {1'b0, r_skid_v}) : 2'd0;

   sat_counter #(
      .W (CNT_W)
   ) u_squash_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_squash_inc),
      .o_cnt (o_squash_cnt)
   );

   assign io_pipe.in_ready  = w_in_ready;
   assign io_pipe.out_valid = r_main_v;
   assign io_pipe.out_data  = r_main;
   // FULL implies main_v, so {skid_v, main_v & ~skid_v} is the entry count.
   assign o_occupancy       = {r_skid_v, r_main_v & ~r_skid_v};

   // A presented word must not change until it is taken or squashed.
   a_out_stable : assert property (@(posedge clk) disable iff (rst)
      (r_main_v && !w_out_fire && !w_flush_eff) |=> (r_main_v && $stable(r_main)));

endmodule
